// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the single register-file write port between the WB pipeline stage and
// a long-latency unit (LLU). WB has normal priority. LLU results wait in a small
// FIFO and drain in free port cycles. If the FIFO head waits too long, a
// one-cycle pipeline stall is forced so that the head can write.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   i_wb_we/addr/data          WB stage write request
//   i_llu_valid/addr/data      LLU result offer; accepted when o_llu_ready=1
//   o_llu_ready                FIFO has room (registered)
//   o_stall_pipe               registered one-cycle stall pulse
//   o_rf_we/addr/data          register-file write port (combinational grant)
//   i_chk_addr_a/b             hazard lookup addresses
//   o_chk_hit_a/b              a live queued entry targets the lookup address
//   o_fifo_count               occupied FIFO entries (registered)
module rf_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_addr,
  input  logic [15:0] i_wb_data,
  input  logic        i_llu_valid,
  input  logic [3:0]  i_llu_addr,
  input  logic [15:0] i_llu_data,
  output logic        o_llu_ready,
  output logic        o_stall_pipe,
  output logic        o_rf_we,
  output logic [3:0]  o_rf_addr,
  output logic [15:0] o_rf_data,
  input  logic [3:0]  i_chk_addr_a,
  input  logic [3:0]  i_chk_addr_b,
  output logic        o_chk_hit_a,
  output logic        o_chk_hit_b,
  output logic [2:0]  o_fifo_count
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = (STARVE_LIMIT > 2) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT - 1);
  localparam logic [2:0]    DEPTH_C    = 3'(DEPTH);
  localparam logic [PW:0]   DEPTH_T    = (PW + 1)'(DEPTH);
  localparam logic [PW-1:0] HEAD_LAST  = PW'(DEPTH - 1);

  // FIFO storage. A live bit is 1 only for occupied, not-yet-killed entries,
  // so the hazard lookup can simply scan all slots.
  logic [3:0]       r_addr [DEPTH];
  logic [15:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [PW-1:0]    r_head;
  logic [2:0]       r_count;
  logic             r_llu_ready;
  logic [CW-1:0]    r_starve;
  logic             r_stall;

  logic          w_head_live;
  logic          w_wb_valid;
  logic          w_grant_wb;
  logic          w_grant_fifo;
  logic          w_pop;
  logic          w_push;
  logic          w_starve_hit;
  logic [PW:0]   w_tail_sum;
  logic [PW-1:0] w_tail;
  logic [PW-1:0] w_head_next;
  logic [2:0]    w_count_next;

  assign w_head_live = r_live[r_head];
  assign w_wb_valid  = i_wb_we & (i_wb_addr != 4'd0);

  // During a stall cycle WB is never granted, even if the head was killed.
  assign w_grant_wb   = ~rst & ~r_stall & w_wb_valid;
  assign w_grant_fifo = ~rst & w_head_live & (r_stall | ~w_wb_valid);

  // A dead head discards itself without using the port.
  assign w_pop  = (r_count != 3'd0) & (w_grant_fifo | ~w_head_live);
  assign w_push = i_llu_valid & r_llu_ready & (i_llu_addr != 4'd0);

  assign w_starve_hit = w_head_live & ~w_grant_fifo & ~r_stall &
                        (r_starve == STARVE_MAX);

  // Tail slot and next head, wrapping for non-power-of-two depths.
  always_comb begin
    w_tail_sum = {1'b0, r_head} + r_count[PW:0];
    if (w_tail_sum >= DEPTH_T) begin
      w_tail = PW'(w_tail_sum - DEPTH_T);
    end else begin
      w_tail = w_tail_sum[PW-1:0];
    end
    if (r_head == HEAD_LAST) begin
      w_head_next = '0;
    end else begin
      w_head_next = r_head + PW'(1);
    end
  end

  // Occupancy update from push/pop.
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 3'd1;
      2'b01:   w_count_next = r_count - 3'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Write-port mux in grant order.
  always_comb begin
    o_rf_we   = w_grant_wb | w_grant_fifo;
    o_rf_addr = 4'd0;
    o_rf_data = 16'd0;
    if (w_grant_wb) begin
      o_rf_addr = i_wb_addr;
      o_rf_data = i_wb_data;
    end else if (w_grant_fifo) begin
      o_rf_addr = r_addr[r_head];
      o_rf_data = r_data[r_head];
    end else begin
      o_rf_addr = 4'd0;
      o_rf_data = 16'd0;
    end
  end

  // Hazard lookup against state as of the start of this cycle.
  always_comb begin
    o_chk_hit_a = 1'b0;
    o_chk_hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i] && (r_addr[i] == i_chk_addr_a) && (i_chk_addr_a != 4'd0)) begin
        o_chk_hit_a = 1'b1;
      end else begin
        o_chk_hit_a = o_chk_hit_a;
      end
      if (r_live[i] && (r_addr[i] == i_chk_addr_b) && (i_chk_addr_b != 4'd0)) begin
        o_chk_hit_b = 1'b1;
      end else begin
        o_chk_hit_b = o_chk_hit_b;
      end
    end
  end

  // FIFO state: kill, then pop, then push (a same-cycle push is younger than
  // the WB write and must survive the kill).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live      <= '0;
      r_head      <= '0;
      r_count     <= 3'd0;
      r_llu_ready <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= 4'd0;
        r_data[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_grant_wb && (r_addr[i] == i_wb_addr)) begin
          r_live[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_live[r_head] <= 1'b0;
        r_head         <= w_head_next;
      end
      if (w_push) begin
        r_addr[w_tail] <= i_llu_addr;
        r_data[w_tail] <= i_llu_data;
        r_live[w_tail] <= 1'b1;
      end
      r_count     <= w_count_next;
      r_llu_ready <= (w_count_next < DEPTH_C);
    end
  end

  // Starvation counter and the one-cycle stall pulse it triggers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_stall <= w_starve_hit;
      if (w_pop || (r_count == 3'd0) || w_starve_hit) begin
        r_starve <= '0;
      end else if (w_head_live && !w_grant_fifo) begin
        r_starve <= r_starve + CW'(1);
      end else begin
        r_starve <= r_starve;
      end
    end
  end

  assign o_llu_ready  = r_llu_ready;
  assign o_stall_pipe = r_stall;
  assign o_fifo_count = r_count;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter (DEPTH=2, STARVE_LIMIT=4). Expected register
// file writes are queued as stimulus is driven and compared, in order, by a
// monitor whenever the DUT asserts rf_we; port-level state is checked directly.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        llu_valid;
  logic [3:0]  llu_addr;
  logic [15:0] llu_data;
  logic        llu_ready;
  logic        stall_pipe;
  logic        rf_we;
  logic [3:0]  rf_addr;
  logic [15:0] rf_data;
  logic [3:0]  chk_addr_a;
  logic [3:0]  chk_addr_b;
  logic        chk_hit_a;
  logic        chk_hit_b;
  logic [2:0]  fifo_count;

  logic [19:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_wb_we(wb_we), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_llu_valid(llu_valid), .i_llu_addr(llu_addr), .i_llu_data(llu_data),
    .o_llu_ready(llu_ready), .o_stall_pipe(stall_pipe),
    .o_rf_we(rf_we), .o_rf_addr(rf_addr), .o_rf_data(rf_data),
    .i_chk_addr_a(chk_addr_a), .i_chk_addr_b(chk_addr_b),
    .o_chk_hit_a(chk_hit_a), .o_chk_hit_b(chk_hit_b),
    .o_fifo_count(fifo_count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic lv, input logic [3:0] la, input logic [15:0] ld);
    wb_we     = we;
    wb_addr   = wa;
    wb_data   = wd;
    llu_valid = lv;
    llu_addr  = la;
    llu_data  = ld;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write on the port must be the oldest expected write.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("rf_spurious", {31'd0, rf_we}, 32'd0);
      end else begin
        check_val("rf_write", {12'd0, rf_addr, rf_data}, {12'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst        = 1'b1;
    chk_addr_a = 4'd0;
    chk_addr_b = 4'd0;
    drive(1'b1, 4'd3, 16'h5555, 1'b0, 4'd0, 16'h0000);

    // Reset: outputs idle, and a WB request is not written while in reset.
    @(negedge clk);
    check_val("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check_val("rst_count", {29'd0, fifo_count}, 32'd0);
    check_val("rst_stall", {31'd0, stall_pipe}, 32'd0);
    next_cycle();
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
    rst = 1'b0;
    next_cycle();
    check_val("rst_ready", {31'd0, llu_ready}, 32'd1);

    // Plain WB write goes straight through.
    drive(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0000);
    exp_q.push_back({4'd3, 16'h1234});
    @(negedge clk);
    check_val("wb_we",    {31'd0, rf_we}, 32'd1);
    check_val("wb_addr",  {28'd0, rf_addr}, 32'd3);
    check_val("wb_data",  {16'd0, rf_data}, 32'h1234);
    check_val("wb_count", {29'd0, fifo_count}, 32'd0);
    check_val("wb_stall", {31'd0, stall_pipe}, 32'd0);
    next_cycle();

    // LLU result drains into an idle port the next cycle.
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 16'hBEEF);
    @(negedge clk);
    check_val("llu_push_nowrite", {31'd0, rf_we}, 32'd0);
    next_cycle();
    exp_q.push_back({4'd5, 16'hBEEF});
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
    @(negedge clk);
    check_val("llu_count1", {29'd0, fifo_count}, 32'd1);
    check_val("llu_drain_addr", {28'd0, rf_addr}, 32'd5);
    next_cycle();
    check_val("llu_count0", {29'd0, fifo_count}, 32'd0);

    // Continuous WB traffic starves two queued LLU results.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, (i % 2 == 0) ? 4'd1 : 4'd2, 16'h1000 + 16'(i),
            (i < 2) ? 1'b1 : 1'b0, (i == 0) ? 4'd8 : 4'd9,
            (i == 0) ? 16'hAAAA : 16'hBBBB);
      if (i == 5) begin
        exp_q.push_back({4'd8, 16'hAAAA});
      end else if (i == 10) begin
        exp_q.push_back({4'd9, 16'hBBBB});
      end else begin
        exp_q.push_back({wb_addr, wb_data});
      end
      @(negedge clk);
      if (i == 2) begin
        check_val("starve_count2", {29'd0, fifo_count}, 32'd2);
        check_val("starve_full_ready", {31'd0, llu_ready}, 32'd0);
      end
      if (i == 4 || i == 6 || i == 9) begin
        check_val($sformatf("starve_nostall_%0d", i), {31'd0, stall_pipe}, 32'd0);
      end
      if (i == 5) begin
        check_val("stall1", {31'd0, stall_pipe}, 32'd1);
        check_val("stall1_addr", {28'd0, rf_addr}, 32'd8);
        check_val("stall1_data", {16'd0, rf_data}, 32'hAAAA);
      end
      if (i == 10) begin
        check_val("stall2", {31'd0, stall_pipe}, 32'd1);
        check_val("stall2_addr", {28'd0, rf_addr}, 32'd9);
        check_val("stall2_data", {16'd0, rf_data}, 32'hBBBB);
      end
      if (i == 11) begin
        check_val("starve_empty", {29'd0, fifo_count}, 32'd0);
      end
      next_cycle();
    end

    // WAW kill: a younger WB write to 7 cancels the queued LLU write to 7.
    chk_addr_a = 4'd7;
    chk_addr_b = 4'd7;
    drive(1'b1, 4'd2, 16'h0002, 1'b1, 4'd7, 16'h1111);
    exp_q.push_back({4'd2, 16'h0002});
    @(negedge clk);
    check_val("kill_hit_pre_push", {31'd0, chk_hit_a}, 32'd0);
    next_cycle();
    drive(1'b1, 4'd7, 16'h2222, 1'b0, 4'd0, 16'h0000);
    exp_q.push_back({4'd7, 16'h2222});
    @(negedge clk);
    check_val("kill_hit_a_before", {31'd0, chk_hit_a}, 32'd1);
    check_val("kill_hit_b_before", {31'd0, chk_hit_b}, 32'd1);
    next_cycle();
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
    @(negedge clk);
    check_val("kill_hit_after", {31'd0, chk_hit_a}, 32'd0);
    check_val("kill_pop_nowrite", {31'd0, rf_we}, 32'd0);
    check_val("kill_count1", {29'd0, fifo_count}, 32'd1);
    next_cycle();
    check_val("kill_count0", {29'd0, fifo_count}, 32'd0);
    chk_addr_a = 4'd0;
    chk_addr_b = 4'd0;

    // Register 0: WB write is dropped, LLU result accepted but not stored.
    drive(1'b1, 4'd0, 16'h7777, 1'b1, 4'd0, 16'h8888);
    @(negedge clk);
    check_val("r0_rf_we", {31'd0, rf_we}, 32'd0);
    check_val("r0_ready", {31'd0, llu_ready}, 32'd1);
    next_cycle();
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
    @(negedge clk);
    check_val("r0_count", {29'd0, fifo_count}, 32'd0);
    check_val("r0_nowrite", {31'd0, rf_we}, 32'd0);
    next_cycle();

    // Mid-cycle reset with a full FIFO and a partially advanced counter.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i % 2 == 0) ? 4'd1 : 4'd2, 16'h2000 + 16'(i),
            (i < 2) ? 1'b1 : 1'b0, (i == 0) ? 4'd12 : 4'd13, 16'h0C0C);
      exp_q.push_back({wb_addr, wb_data});
      @(negedge clk);
      if (i < 3) begin
        next_cycle();
      end
    end
    check_val("prerst_count", {29'd0, fifo_count}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_val("midrst_count", {29'd0, fifo_count}, 32'd0);
    check_val("midrst_stall", {31'd0, stall_pipe}, 32'd0);
    check_val("midrst_rf_we", {31'd0, rf_we}, 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val($sformatf("postrst_stall_%0d", i), {31'd0, stall_pipe}, 32'd0);
      next_cycle();
    end
    check_val("postrst_count", {29'd0, fifo_count}, 32'd0);

    check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
